munoc_rr_lock_arbiter: RTL and testbench
========================================

Name: munoc_rr_lock_arbiter

Overview:
- Round-robin arbiter with packet lock for N flit sources competing for one munoc output channel.
- Selects one requester, holds that grant from the first accepted beat to the beat marked last, then advances priority.
- Sits directly upstream of the per-channel grant hold register. Its grant_index/grant_valid feed that register's enable and next-value inputs; its clear feeds that register's sync clear.

Parameters:
- NUM_REQ, 4, number of requesting sources (2..16; non-power-of-two allowed).
- IDX_W, clog2(NUM_REQ) (min 1), width of grant index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous clear; same effect as reset, sampled on clk.
- req_valid  in  NUM_REQ  per-source beat valid.
- req_last  in  NUM_REQ  per-source last-beat flag; qualified by req_valid.
- req_ready  out  NUM_REQ  per-source ready; at most one bit high.
- out_valid  out  1  selected source's valid.
- out_last  out  1  selected source's last flag.
- out_ready  in  1  downstream ready.
- grant_valid  out  1  a source is currently granted.
- grant_index  out  IDX_W  granted source index (external data mux select).
- grant_onehot  out  NUM_REQ  one-hot form of grant_index.
- locked  out  1  mid-packet; grant frozen.

Behaviour:
- State: IDLE, LOCKED. Registers: state, ptr (IDX_W, highest-priority index), lock_idx (IDX_W).
- Reset (rst=1, async) or clear=1 (sync): state=IDLE, ptr=0, lock_idx=0. All outputs then follow the combinational rules below.
- Beat handshake: hs = out_valid & out_ready.
- Pick function, combinational: the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ (not modulo 2^IDX_W).

IDLE:
- sel = pick. grant_valid = |req_valid.
- If no request: grant_index=0, grant_onehot=0, out_valid=0, out_last=0, req_ready=0.
- Grant is visible in the same cycle as the request (zero-cycle arbitration latency).
- hs & !out_last: next state LOCKED, lock_idx=sel, ptr unchanged.
- hs & out_last (single-beat packet): stay IDLE, ptr = (sel+1) mod NUM_REQ.
- No hs: nothing registered. The grant may change next cycle if requests change.

LOCKED:
- sel = lock_idx regardless of other requests. grant_valid=1, locked=1.
- out_valid = req_valid[lock_idx]. If the locked source drops valid, the grant is still held.
- hs & out_last: next state IDLE, ptr = (lock_idx+1) mod NUM_REQ.
- hs & !out_last: stay LOCKED.

Common rules:
- out_last = req_last[sel] & req_valid[sel].
- req_ready = grant_onehot & {NUM_REQ{out_ready}}. Ready is never asserted to an ungranted source.
- grant_onehot = (grant_valid ? 1<<sel : 0). grant_index = sel when grant_valid, else 0.
- locked=0 in IDLE.
- clear in the same cycle as hs: clear wins. Next state is IDLE with ptr=0, and the beat is still transferred, because ready/valid are combinational that cycle.
- Reset mid-packet: the lock is dropped immediately (async). Upstream must tolerate the truncated packet; the downstream hold register is reset by the same rst.
- No starvation: each source waits at most NUM_REQ-1 packets.

Decomposition:
- Shared package munoc_arb_pkg:
  - state encoding constants ARB_IDLE=0, ARB_LOCKED=1.
  - clog2 constant function for IDX_W.
  - helper for wrap-increment modulo NUM_REQ.
- Sub-module munoc_rr_pick: purely combinational rotating priority encoder. Inputs: req_valid, ptr. Outputs: found, idx.
- Parent holds the FSM, ptr, lock_idx and the output muxing.

Test Plan:
- Reset then idle: rst pulse, all req_valid=0 -> grant_valid=0, grant_index=0, req_ready=0, locked=0, ptr=0.
- Fairness, single-beat: NUM_REQ=4, req_valid=4'b1111, req_last=4'b1111, out_ready=1 for 8 cycles -> grant_index sequence 0,1,2,3,0,1,2,3.
- Packet lock:
  - Stimulus: source 2 sends 3 beats (last on beat 3); source 0 requests from cycle 1; out_ready=1.
  - Response: grant_index=2 and locked=1 for beats 2-3; req_ready[0]=0 throughout; next grant is 0; ptr=3 after the packet.
- Backpressure and valid gap inside a packet:
  - Stimulus: locked on source 1; out_ready=0 for 2 cycles; then req_valid[1]=0 for 1 cycle while source 3 requests.
  - Response: grant_index stays 1, out_valid=0 during the gap, no state change until the last beat handshakes.
- Wrap with NUM_REQ=3 (IDX_W=2): ptr=2, req_valid=3'b011 -> grant 0 (index 3 never produced); after a single-beat handshake, ptr=1.
- Clear vs handshake: LOCKED on source 3, then clear=1 in the same cycle as a non-last hs -> beat accepted, next cycle state IDLE, ptr=0, locked=0. Separately, rst asserted mid-packet -> locked=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/munoc_arb_pkg.sv
// Shared definitions for the munoc round-robin lock arbiter.
//   arb_state_e   : FSM encoding (ARB_IDLE=0, ARB_LOCKED=1)
//   arb_clog2     : index width for a given requester count (minimum 1)
//   arb_wrap_inc  : increment modulo the requester count (not modulo 2^W)
package munoc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int arb_clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int arb_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/munoc_rr_pick.sv
// Combinational rotating priority encoder.
// Ports:
//   i_req_valid : per-source request vector
//   i_ptr       : highest-priority index (must be < NUM_REQ)
//   o_found     : at least one request present
//   o_idx       : first requesting index scanning i_ptr, i_ptr+1, ... mod NUM_REQ
module munoc_rr_pick
  import munoc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = arb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  // Doubling the vector lets a plain part-select perform the rotation:
  // bit j of w_rot is request (ptr + j) mod NUM_REQ.
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W:0]       w_off;
  logic [IDX_W:0]       w_sum;

  assign w_dbl = {i_req_valid, i_req_valid};
  assign w_rot = w_dbl[i_ptr +: NUM_REQ];

  always_comb begin
    o_found = |w_rot;
    w_off   = '0;
    // Scan downwards so the smallest offset is the one left standing.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = (IDX_W+1)'(j);
      end
    end
    // ptr + offset is at most 2*NUM_REQ-2, so one conditional subtract wraps it.
    w_sum = {1'b0, i_ptr} + w_off;
    if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
      w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
    end
    o_idx = IDX_W'(w_sum);
  end

endmodule

// File: rtl/munoc_rr_lock_arbiter.sv
// Round-robin arbiter with packet lock for one munoc output channel.
// A grant is held from the first accepted non-last beat until the last beat
// handshakes; priority then moves to the source after the one just served.
// Ports:
//   i_clk, i_rst (async, active high), i_clear (sync, same effect as reset)
//   i_req_valid / i_req_last / o_req_ready : per-source beat handshake
//   o_out_valid / o_out_last / i_out_ready : selected beat to downstream
//   o_grant_valid / o_grant_index / o_grant_onehot : current grant
//   o_locked : mid-packet, grant frozen
module munoc_rr_lock_arbiter
  import munoc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = arb_clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [NUM_REQ-1:0] i_req_last,
  output logic [NUM_REQ-1:0] o_req_ready,
  output logic               o_out_valid,
  output logic               o_out_last,
  input  logic               i_out_ready,
  output logic               o_grant_valid,
  output logic [IDX_W-1:0]   o_grant_index,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic               o_locked
);

  arb_state_e       r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [IDX_W-1:0] r_lock_idx, w_lock_idx_next;

  logic               w_pick_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_is_locked;
  logic [IDX_W-1:0]   w_sel;
  logic               w_grant_valid;
  logic               w_out_valid;
  logic               w_out_last;
  logic               w_hs;
  logic [IDX_W-1:0]   w_sel_inc;
  logic [NUM_REQ-1:0] w_onehot;

  munoc_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req_valid (i_req_valid),
    .i_ptr       (r_ptr),
    .o_found     (w_pick_found),
    .o_idx       (w_pick_idx)
  );

  assign w_is_locked   = (r_state == ARB_LOCKED);
  // While locked, other sources are ignored even if the owner drops valid.
  assign w_sel         = w_is_locked ? r_lock_idx : w_pick_idx;
  assign w_grant_valid = w_is_locked | w_pick_found;
  assign w_out_valid   = w_grant_valid & i_req_valid[w_sel];
  assign w_out_last    = w_out_valid & i_req_last[w_sel];
  assign w_hs          = w_out_valid & i_out_ready;
  assign w_sel_inc     = IDX_W'(arb_wrap_inc(int'(w_sel), NUM_REQ));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign w_onehot[gi] = w_grant_valid & (w_sel == IDX_W'(gi));
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_lock_idx <= w_lock_idx_next;
    end
  end

  // Next-state logic. Clear overrides any handshake in the same cycle; the
  // beat itself still transfers because ready/valid are combinational.
  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_lock_idx_next = r_lock_idx;
    if (i_clear) begin
      w_state_next    = ARB_IDLE;
      w_ptr_next      = '0;
      w_lock_idx_next = '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_hs) begin
            if (w_out_last) begin
              w_ptr_next = w_sel_inc;
            end else begin
              w_state_next    = ARB_LOCKED;
              w_lock_idx_next = w_sel;
            end
          end
        end
        ARB_LOCKED: begin
          if (w_hs && w_out_last) begin
            w_state_next = ARB_IDLE;
            w_ptr_next   = w_sel_inc;
          end
        end
        default: begin
          w_state_next = ARB_IDLE;
        end
      endcase
    end
  end

  // Output logic.
  always_comb begin
    o_grant_valid  = w_grant_valid;
    o_grant_index  = w_grant_valid ? w_sel : '0;
    o_grant_onehot = w_onehot;
    o_req_ready    = w_onehot & {NUM_REQ{i_out_ready}};
    o_out_valid    = w_out_valid;
    o_out_last     = w_out_last;
    o_locked       = w_is_locked;
  end

endmodule

// File: tb/tb_munoc_rr_lock_arbiter.sv
module tb_munoc_rr_lock_arbiter;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       grant_valid;
  logic [1:0] grant_index;
  logic [3:0] grant_onehot;
  logic       locked;

  logic       clear3;
  logic [2:0] req_valid3;
  logic [2:0] req_last3;
  logic [2:0] req_ready3;
  logic       out_valid3;
  logic       out_last3;
  logic       out_ready3;
  logic       grant_valid3;
  logic [1:0] grant_index3;
  logic [2:0] grant_onehot3;
  logic       locked3;

  int total;
  int bad;

  munoc_rr_lock_arbiter #(.NUM_REQ(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (clear),
    .i_req_valid    (req_valid),
    .i_req_last     (req_last),
    .o_req_ready    (req_ready),
    .o_out_valid    (out_valid),
    .o_out_last     (out_last),
    .i_out_ready    (out_ready),
    .o_grant_valid  (grant_valid),
    .o_grant_index  (grant_index),
    .o_grant_onehot (grant_onehot),
    .o_locked       (locked)
  );

  munoc_rr_lock_arbiter #(.NUM_REQ(3)) dut3 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (clear3),
    .i_req_valid    (req_valid3),
    .i_req_last     (req_last3),
    .o_req_ready    (req_ready3),
    .o_out_valid    (out_valid3),
    .o_out_last     (out_last3),
    .i_out_ready    (out_ready3),
    .o_grant_valid  (grant_valid3),
    .o_grant_index  (grant_index3),
    .o_grant_onehot (grant_onehot3),
    .o_locked       (locked3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] rl;
    logic       rdy;
    logic       clr;
    logic       gv;
    logic [1:0] gi;
    logic [3:0] rr;
    logic       ov;
    logic       ol;
    logic       lk;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b0;
    clear3     = 1'b0;
    req_valid3 = '0;
    req_last3  = '0;
    out_ready3 = 1'b0;

    // Per-cycle vectors: rv, rl, rdy, clr | gv, gi, ready, ov, ol, locked
    // reset then idle
    tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0});
    // fairness with single-beat packets: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) begin
      tbl.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 2'(k % 4), 4'(1 << (k % 4)), 1'b1, 1'b1, 1'b0});
    end
    // packet lock: source 2, three beats, source 0 joins on beat 2
    tbl.push_back('{4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'b0101, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 1'b1});
    // next grant 0 (no ready), then source 3 wins over 0 -> ptr was 3
    tbl.push_back('{4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{4'b1001, 4'b1001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 1'b0});
    // backpressure and valid gap while locked on source 1
    tbl.push_back('{4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'b1010, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 1'b0});
    // clear vs handshake: move ptr to 1, lock on 3, clear with a non-last beat
    tbl.push_back('{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1});
    // after clear: idle with ptr=0 so source 0 beats source 3
    tbl.push_back('{4'b1001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) begin
      @(negedge clk);
      req_valid = tbl[n].rv;
      req_last  = tbl[n].rl;
      out_ready = tbl[n].rdy;
      clear     = tbl[n].clr;
      #1;
      $display("vec %0d: rv=%b rl=%b rdy=%b clr=%b -> gv=%b gi=%0d ready=%b ov=%b ol=%b lk=%b",
               n, req_valid, req_last, out_ready, clear,
               grant_valid, grant_index, req_ready, out_valid, out_last, locked);
      chk($sformatf("v%0d grant_valid", n), int'(grant_valid), int'(tbl[n].gv));
      chk($sformatf("v%0d grant_index", n), int'(grant_index), int'(tbl[n].gi));
      chk($sformatf("v%0d req_ready", n), int'(req_ready), int'(tbl[n].rr));
      chk($sformatf("v%0d grant_onehot", n), int'(grant_onehot),
          int'(tbl[n].gv ? (4'b0001 << tbl[n].gi) : 4'b0000));
      chk($sformatf("v%0d out_valid", n), int'(out_valid), int'(tbl[n].ov));
      chk($sformatf("v%0d out_last", n), int'(out_last), int'(tbl[n].ol));
      chk($sformatf("v%0d locked", n), int'(locked), int'(tbl[n].lk));
    end

    // Async reset mid-packet: lock on source 2, then drop it between edges.
    @(negedge clk);
    clear     = 1'b0;
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0101;
    out_ready = 1'b0;
    #1;
    $display("rst-mid: before rst gi=%0d lk=%b", grant_index, locked);
    chk("rstmid locked_before", int'(locked), 1);
    chk("rstmid index_before", int'(grant_index), 2);
    #1;
    rst = 1'b1;
    #1;
    $display("rst-mid: after rst gi=%0d lk=%b", grant_index, locked);
    chk("rstmid locked_after", int'(locked), 0);
    chk("rstmid index_after", int'(grant_index), 0);
    #1;
    rst = 1'b0;

    // NUM_REQ=3 wrap: single beat from 1 -> ptr=2; then {0,1} request -> 0.
    @(negedge clk);
    req_valid  = '0;
    req_valid3 = 3'b010;
    req_last3  = 3'b010;
    out_ready3 = 1'b1;
    #1;
    $display("wrap3 a: gi=%0d oh=%b", grant_index3, grant_onehot3);
    chk("wrap3 first_index", int'(grant_index3), 1);
    @(negedge clk);
    req_valid3 = 3'b011;
    req_last3  = 3'b011;
    #1;
    $display("wrap3 b: gi=%0d oh=%b ready=%b", grant_index3, grant_onehot3, req_ready3);
    chk("wrap3 wrap_index", int'(grant_index3), 0);
    chk("wrap3 wrap_onehot", int'(grant_onehot3), 1);
    chk("wrap3 wrap_ready", int'(req_ready3), 1);
    @(negedge clk);
    req_valid3 = 3'b111;
    req_last3  = 3'b000;
    out_ready3 = 1'b0;
    #1;
    $display("wrap3 c: gi=%0d lk=%b", grant_index3, locked3);
    chk("wrap3 ptr_after", int'(grant_index3), 1);
    chk("wrap3 not_locked", int'(locked3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
